// File: rtl/float_accumulator.sv
// Folds a batch of floats into a running sum through an external float_adder,
// presenting the sum and sticky adder flags on a valid/ready result port.
module float_accumulator #(
   parameter int FLOAT_SIZE    = 32,
   parameter int EXPONENT_SIZE = 8,
   parameter int MANTISSA_SIZE = 23,
   parameter int BIAS          = 127,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] length,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FLOAT_SIZE-1:0]  in_data,
   output logic [FLOAT_SIZE-1:0]  add_a,
   output logic [FLOAT_SIZE-1:0]  add_b,
   input  logic [FLOAT_SIZE-1:0]  add_out,
   input  logic                   add_overflow,
   input  logic                   add_underflow,
   input  logic                   add_inexact,
   output logic [FLOAT_SIZE-1:0]  result,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   inexact,
   output logic                   zero,
   output logic                   busy
);

   // Format parameters must describe the same float as the companion adder.
   if ((1 + EXPONENT_SIZE + MANTISSA_SIZE != FLOAT_SIZE) ||
       (BIAS != (1 << (EXPONENT_SIZE - 1)) - 1)) begin : g_bad_format
      $error("float_accumulator: inconsistent float format parameters");
   end

   typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

   state_t                 state, next_state;
   logic [FLOAT_SIZE-1:0]  acc;
   logic [COUNT_WIDTH-1:0] count;
   logic                   accept;
   logic                   last;

   assign add_a  = acc;
   assign add_b  = in_data;
   assign result = acc;
   assign zero   = ~|acc[FLOAT_SIZE-2:0];

   assign accept = in_valid && in_ready && (state == FIRST || state == ACCUM);
   assign last   = (count == COUNT_WIDTH'(1));

   always_comb begin
      next_state = state;
      case (state)
         IDLE:         if (start) next_state = (length == '0) ? DONE : FIRST;
         FIRST, ACCUM: if (accept) next_state = last ? DONE : ACCUM;
         DONE:         if (result_ready) next_state = IDLE;
         default:      next_state = IDLE;
      endcase
   end

   // Handshake outputs are registered from next_state so they are glitch-free
   // and in_ready never depends combinationally on in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         inexact      <= 1'b0;
         in_ready     <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= next_state;
         in_ready     <= (next_state == FIRST) || (next_state == ACCUM);
         result_valid <= (next_state == DONE);
         busy         <= (next_state != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  acc       <= '0;
                  count     <= length;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  inexact   <= 1'b0;
               end
            end
            FIRST: begin
               if (accept) begin
                  acc   <= in_data;
                  count <= count - 1'b1;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc       <= add_out;
                  count     <= count - 1'b1;
                  overflow  <= overflow  | add_overflow;
                  underflow <= underflow | add_underflow;
                  inexact   <= inexact   | add_inexact;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_accumulator.sv
// Directed bench for float_accumulator: a table of batches plus hand-written
// sequences for backpressure, mid-batch reset and ignored start pulses.
module tb_float_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] length;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] add_a, add_b, add_out;
   logic        add_overflow, add_underflow, add_inexact;
   logic [31:0] result;
   logic        result_valid;
   logic        result_ready;
   logic        overflow, underflow, inexact, zero, busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   float_accumulator #(
      .FLOAT_SIZE(32), .EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .BIAS(127), .COUNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .length(length),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .add_a(add_a), .add_b(add_b), .add_out(add_out),
      .add_overflow(add_overflow), .add_underflow(add_underflow), .add_inexact(add_inexact),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .overflow(overflow), .underflow(underflow), .inexact(inexact),
      .zero(zero), .busy(busy)
   );

   // Stand-in for float_adder: only the sums this bench needs, hand-computed.
   // Anything else yields a poison value with every flag raised.
   always_comb begin
      add_overflow  = 1'b0;
      add_underflow = 1'b0;
      add_inexact   = 1'b0;
      case ({add_a, add_b})
         {32'h3F800000, 32'h40000000}: add_out = 32'h40400000;
         {32'h40400000, 32'h40400000}: add_out = 32'h40C00000;
         {32'h3F800000, 32'h3F000000}: add_out = 32'h3FC00000;
         {32'h3F800000, 32'hBF800000}: add_out = 32'h00000000;
         {32'h00800000, 32'h80700000}: begin
            add_out       = 32'h00100000;
            add_underflow = 1'b1;
         end
         {32'h7F7FFFFF, 32'h7F7FFFFF}: begin
            add_out      = 32'h7F800000;
            add_overflow = 1'b1;
            add_inexact  = 1'b1;
         end
         default: begin
            add_out       = 32'hDEADBEEF;
            add_overflow  = 1'b1;
            add_underflow = 1'b1;
            add_inexact   = 1'b1;
         end
      endcase
   end

   typedef struct {
      string           name;
      logic [15:0]     len;
      logic [3:0][31:0] e;
      logic [31:0]     res;
      logic            ov, un, inx, zr;
      int              cyc;
   } vec_t;

   function automatic vec_t mk(string name, logic [15:0] len,
                               logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                               logic [31:0] e3, logic [31:0] res,
                               logic ov, logic un, logic inx, logic zr, int cyc);
      vec_t v;
      v.name = name; v.len = len;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
      v.res = res; v.ov = ov; v.un = un; v.inx = inx; v.zr = zr; v.cyc = cyc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge. Streams elements with 'gap' idle cycles after each
   // accept and returns the number of edges from the start edge to result_valid.
   task automatic run_batch(input logic [15:0] len, input logic [3:0][31:0] e,
                            input int gap, output int cyc);
      int idx = 0;
      int gapcnt = 0;
      logic hs;
      start  = 1'b1;
      length = len;
      tick();
      start = 1'b0;
      cyc = 1;
      while (!result_valid && cyc < 100) begin
         if (gapcnt > 0) begin
            in_valid = 1'b0;
            in_data  = 32'h12345678;
            gapcnt--;
         end else if (idx < int'(len)) begin
            in_valid = 1'b1;
            in_data  = e[idx];
         end else begin
            in_valid = 1'b0;
         end
         hs = in_valid && in_ready;
         tick();
         cyc++;
         if (hs) begin
            idx++;
            gapcnt = gap;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic release_result();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("release_valid", 32'(result_valid), 32'd0);
      chk("release_busy", 32'(busy), 32'd0);
   endtask

   vec_t vecs [7];
   int   cyc;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk("sum3", 16'd3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0,
                   32'h40C00000, 0, 0, 0, 0, 4);
      vecs[1] = mk("len0", 16'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                   32'h00000000, 0, 0, 0, 1, 1);
      vecs[2] = mk("ovf", 16'd2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0,
                   32'h7F800000, 1, 0, 1, 0, 3);
      vecs[3] = mk("single", 16'd1, 32'h40000000, 32'h0, 32'h0, 32'h0,
                   32'h40000000, 0, 0, 0, 0, 2);
      vecs[4] = mk("half", 16'd2, 32'h3F800000, 32'h3F000000, 32'h0, 32'h0,
                   32'h3FC00000, 0, 0, 0, 0, 3);
      vecs[5] = mk("unf", 16'd2, 32'h00800000, 32'h80700000, 32'h0, 32'h0,
                   32'h00100000, 0, 1, 0, 0, 3);
      vecs[6] = mk("cancel", 16'd2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0,
                   32'h00000000, 0, 0, 0, 1, 3);

      rst_n = 1'b0; start = 1'b0; length = '0; in_valid = 1'b0;
      in_data = '0; result_ready = 1'b0;
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_result_valid", 32'(result_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_zero", 32'(zero), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         run_batch(vecs[i].len, vecs[i].e, 0, cyc);
         chk({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cyc));
         chk({vecs[i].name, "_valid"}, 32'(result_valid), 32'd1);
         chk({vecs[i].name, "_result"}, result, vecs[i].res);
         chk({vecs[i].name, "_flags"}, {28'd0, overflow, underflow, inexact, zero},
             {28'd0, vecs[i].ov, vecs[i].un, vecs[i].inx, vecs[i].zr});
         chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd0);
         chk({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
         release_result();
      end

      // Input gaps, then result held under backpressure with in_valid high.
      run_batch(16'd2, {32'h0, 32'h0, 32'h3F000000, 32'h3F800000}, 3, cyc);
      chk("gap_cycles", 32'(cyc), 32'd6);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 32'h3F800000;
         tick();
         chk("hold_result", result, 32'h3FC00000);
         chk("hold_valid", 32'(result_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_result();

      // Overflow is sticky, and cleared by the following start.
      run_batch(16'd2, {32'h0, 32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF}, 0, cyc);
      chk("sticky_ovf", 32'(overflow), 32'd1);
      release_result();
      start = 1'b1; length = 16'd2;
      tick();
      start = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("first_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 32'h3F800000;
      tick();
      in_data = 32'h3F000000;
      tick();
      in_valid = 1'b0;
      chk("after_clear_result", result, 32'h3FC00000);
      release_result();

      // Reset after two of four elements aborts the batch immediately.
      start = 1'b1; length = 16'd4;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 32'h3F800000;
      tick();
      in_data = 32'h40000000;
      tick();
      in_valid = 1'b0;
      chk("pre_reset_acc", result, 32'h40400000);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk("abort_valid", 32'(result_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", result, 32'h0);
      chk("abort_zero", 32'(zero), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_idle", 32'(busy), 32'd0);
      run_batch(16'd1, {32'h0, 32'h0, 32'h0, 32'h40000000}, 0, cyc);
      chk("post_reset_result", result, 32'h40000000);
      chk("post_reset_cycles", 32'(cyc), 32'd2);
      release_result();

      // start pulses in ACCUM and DONE are ignored.
      start = 1'b1; length = 16'd3;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 32'h3F800000;
      tick();
      in_data = 32'h40000000; start = 1'b1; length = 16'd0;
      tick();
      start = 1'b0;
      chk("accum_start_busy", 32'(busy), 32'd1);
      chk("accum_start_valid", 32'(result_valid), 32'd0);
      in_data = 32'h40400000;
      tick();
      in_valid = 1'b0;
      chk("accum_start_result", result, 32'h40C00000);
      chk("accum_start_done", 32'(result_valid), 32'd1);
      start = 1'b1; length = 16'd1;
      tick();
      chk("done_start_valid", 32'(result_valid), 32'd1);
      chk("done_start_result", result, 32'h40C00000);
      result_ready = 1'b1;
      tick();
      start = 1'b0; result_ready = 1'b0;
      chk("done_start_ready_valid", 32'(result_valid), 32'd0);
      chk("done_start_ready_busy", 32'(busy), 32'd0);
      tick();
      chk("start_not_latched", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
